// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-read-port integer register file for the pipelined core.
//   Reads are registered (one cycle latency), with an optional same-cycle
//   write-to-read bypass, and a per-register busy scoreboard for hazard
//   detection. Storage is cleared by an NREG-cycle sweep after reset rather
//   than by a wide asynchronous clear.
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ready      : 1 once the init sweep has finished
//   rd_en      : capture every read port this cycle
//   rs_addr    : read addresses, port p at [p*AW +: AW]
//   rs_data    : registered read data, port p at [p*XLEN +: XLEN]
//   rs_busy    : registered busy flag per read port
//   we         : writeback enable
//   rd_addr    : writeback address
//   rd_data    : writeback data
//   busy_set   : mark busy_addr as having a pending producer
//   busy_addr  : register to mark busy
module register_file_mp #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRP      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        ready,
   input  logic                        rd_en,
   input  logic [NRP*$clog2(NREG)-1:0] rs_addr,
   output logic [NRP*XLEN-1:0]         rs_data,
   output logic [NRP-1:0]              rs_busy,
   input  logic                        we,
   input  logic [$clog2(NREG)-1:0]     rd_addr,
   input  logic [XLEN-1:0]             rd_data,
   input  logic                        busy_set,
   input  logic [$clog2(NREG)-1:0]     busy_addr
);

   localparam int AW = $clog2(NREG);
   // One extra bit so addresses can be range-checked against NREG exactly.
   localparam logic [AW:0] LIM = (AW+1)'(NREG);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t               r_state;
   logic [AW-1:0]        r_idx;
   logic                 r_ready;
   logic [XLEN-1:0]      r_mem [NREG];
   logic [NREG-1:0]      r_busy;
   logic [NRP*XLEN-1:0]  r_rs_data;
   logic [NRP-1:0]       r_rs_busy;

   logic                 w_wr_ok;
   logic                 w_set_ok;
   logic [NREG-1:0]      w_busy_nxt;
   logic [AW-1:0]        w_addr;
   logic [NRP*XLEN-1:0]  w_rs_data;
   logic [NRP-1:0]       w_rs_busy;

   always_comb begin
      w_wr_ok  = (r_state == ST_READY) && we && ({1'b0, rd_addr} < LIM)
                 && !((ZERO_REG != 0) && (rd_addr == '0));
      w_set_ok = (r_state == ST_READY) && busy_set && ({1'b0, busy_addr} < LIM)
                 && !((ZERO_REG != 0) && (busy_addr == '0));
   end

   // Clear first, then set, so a same-address set wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_ok)  w_busy_nxt[rd_addr]   = 1'b0;
      if (w_set_ok) w_busy_nxt[busy_addr] = 1'b1;
   end

   // Busy is taken from the post-edge scoreboard so it agrees with bypassed data.
   always_comb begin
      w_rs_data = '0;
      w_rs_busy = '0;
      w_addr    = '0;
      for (int unsigned p = 0; p < NRP; p++) begin
         w_addr = rs_addr[p*AW +: AW];
         if (({1'b0, w_addr} < LIM) && !((ZERO_REG != 0) && (w_addr == '0))) begin
            if ((BYPASS != 0) && w_wr_ok && (rd_addr == w_addr))
               w_rs_data[p*XLEN +: XLEN] = rd_data;
            else
               w_rs_data[p*XLEN +: XLEN] = r_mem[w_addr];
            w_rs_busy[p] = w_busy_nxt[w_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_INIT;
         r_idx     <= '0;
         r_ready   <= 1'b0;
         r_busy    <= '0;
         r_rs_data <= '0;
         r_rs_busy <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_idx == AW'(NREG-1)) begin
                  r_state <= ST_READY;
                  r_ready <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_READY: begin
               r_busy <= w_busy_nxt;
               if (rd_en) begin
                  r_rs_data <= w_rs_data;
                  r_rs_busy <= w_rs_busy;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // Storage has no reset; the sweep zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT)
         r_mem[r_idx] <= '0;
      else if (w_wr_ok)
         r_mem[rd_addr] <= rd_data;
   end

   assign ready   = r_ready;
   assign rs_data = r_rs_data;
   assign rs_busy = r_rs_busy;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [95:0] data;
      logic [2:0]  busy;
      string       name;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   // DUT A: defaults (NREG=32, NRP=2, BYPASS=1)
   logic        a_rst_n, a_ready, a_rd_en, a_we, a_busy_set;
   logic [9:0]  a_rs_addr;
   logic [63:0] a_rs_data;
   logic [1:0]  a_rs_busy;
   logic [4:0]  a_rd_addr, a_busy_addr;
   logic [31:0] a_rd_data;

   // DUT B: NREG=24, NRP=3, BYPASS=0
   logic        b_rst_n, b_ready, b_rd_en, b_we, b_busy_set;
   logic [14:0] b_rs_addr;
   logic [95:0] b_rs_data;
   logic [2:0]  b_rs_busy;
   logic [4:0]  b_rd_addr, b_busy_addr;
   logic [31:0] b_rd_data;

   register_file_mp #(.XLEN(32), .NREG(32), .NRP(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .ready(a_ready), .rd_en(a_rd_en),
      .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
      .we(a_we), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .busy_set(a_busy_set), .busy_addr(a_busy_addr));

   register_file_mp #(.XLEN(32), .NREG(24), .NRP(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .ready(b_ready), .rd_en(b_rd_en),
      .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
      .we(b_we), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .busy_set(b_busy_set), .busy_addr(b_busy_addr));

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: a response is presented the cycle after an accepted rd_en.
   logic a_pend = 1'b0;
   logic b_pend = 1'b0;
   always @(posedge clk) begin
      a_pend = a_rd_en && a_ready;
      b_pend = b_rd_en && b_ready;
   end

   always @(negedge clk) begin
      if (a_pend) begin
         if (qa.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL a_unexpected: response %h with nothing expected", a_rs_data);
         end else begin
            ea = qa.pop_front();
            chk({ea.name, "_data"}, 96'(a_rs_data), ea.data);
            chk({ea.name, "_busy"}, 96'(a_rs_busy), 96'(ea.busy));
         end
      end
      if (b_pend) begin
         if (qb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL b_unexpected: response %h with nothing expected", b_rs_data);
         end else begin
            eb = qb.pop_front();
            chk({eb.name, "_data"}, b_rs_data, eb.data);
            chk({eb.name, "_busy"}, 96'(b_rs_busy), 96'(eb.busy));
         end
      end
   end

   task automatic a_op(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit bs, input logic [4:0] ba, input bit re,
                       input logic [4:0] p0, input logic [4:0] p1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] ebz, input string nm);
      exp_t e;
      a_we = we; a_rd_addr = wa; a_rd_data = wd;
      a_busy_set = bs; a_busy_addr = ba;
      a_rd_en = re; a_rs_addr = {p1, p0};
      if (re) begin
         e.data = 96'({e1, e0}); e.busy = 3'(ebz); e.name = nm;
         qa.push_back(e);
      end
      @(posedge clk); #1;
      a_we = 1'b0; a_busy_set = 1'b0; a_rd_en = 1'b0;
   endtask

   task automatic b_op(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit bs, input logic [4:0] ba, input bit re,
                       input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [2:0] ebz, input string nm);
      exp_t e;
      b_we = we; b_rd_addr = wa; b_rd_data = wd;
      b_busy_set = bs; b_busy_addr = ba;
      b_rd_en = re; b_rs_addr = {p2, p1, p0};
      if (re) begin
         e.data = {e2, e1, e0}; e.busy = ebz; e.name = nm;
         qb.push_back(e);
      end
      @(posedge clk); #1;
      b_we = 1'b0; b_busy_set = 1'b0; b_rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d miscompares so far", n_bad);
      $fatal(1, "timeout");
   end

   initial begin
      a_rst_n = 1'b0; a_rd_en = 1'b0; a_we = 1'b0; a_busy_set = 1'b0;
      a_rs_addr = '0; a_rd_addr = '0; a_rd_data = '0; a_busy_addr = '0;
      b_rst_n = 1'b0; b_rd_en = 1'b0; b_we = 1'b0; b_busy_set = 1'b0;
      b_rs_addr = '0; b_rd_addr = '0; b_rd_data = '0; b_busy_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("a_rst_ready", 96'(a_ready), 96'(0));
      chk("a_rst_data",  96'(a_rs_data), 96'(0));
      chk("a_rst_busy",  96'(a_rs_busy), 96'(0));
      chk("b_rst_ready", 96'(b_ready), 96'(0));
      chk("b_rst_data",  b_rs_data, 96'(0));

      // Sweep timing; B is pulsed into reset at sweep idx 10 and restarts.
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      for (int i = 1; i <= 36; i++) begin
         @(posedge clk); #1;
         chk("a_ready_sweep", 96'(a_ready), 96'(i >= 32));
         chk("b_ready_sweep", 96'(b_ready), 96'(i >= 35));
         if (i == 10) b_rst_n = 1'b0;
         if (i == 11) b_rst_n = 1'b1;
      end

      // A: every register reads zero after the sweep
      for (int i = 0; i < 32; i++)
         a_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'(i), 5'(31 - i), 32'h0, 32'h0, 2'b00, "a_init_zero");

      a_op(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, "");
      a_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, "a_wr_rd");
      a_op(1, 5'd7, 32'h1234, 0, 5'd0, 1, 5'd7, 5'd7, 32'h1234, 32'h1234, 2'b00, "a_bypass");
      a_op(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, "");
      a_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, "a_zero_reg");
      a_op(0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, "");
      a_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd9, 5'd5, 32'h0, 32'hDEADBEEF, 2'b01, "a_busy_set");
      a_op(1, 5'd9, 32'hAA, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, "");
      a_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd9, 5'd9, 32'hAA, 32'hAA, 2'b00, "a_busy_clr");
      a_op(1, 5'd9, 32'hBB, 1, 5'd9, 1, 5'd9, 5'd9, 32'hBB, 32'hBB, 2'b11, "a_set_wins");
      a_op(0, 5'd0, 32'h0, 1, 5'd11, 1, 5'd11, 5'd9, 32'h0, 32'hBB, 2'b11, "a_set_vis");
      a_op(1, 5'd11, 32'hCC, 0, 5'd0, 1, 5'd11, 5'd9, 32'hCC, 32'hBB, 2'b10, "a_clr_vis");
      a_op(1, 5'd11, 32'hDD, 0, 5'd0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, "");
      chk("a_hold_data", 96'(a_rs_data), 96'({32'hBB, 32'hCC}));
      chk("a_hold_busy", 96'(a_rs_busy), 96'(2'b10));
      a_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd11, 5'd7, 32'hDD, 32'h1234, 2'b00, "a_after_hold");

      // B: no bypass, out-of-range addresses, top register
      b_op(1, 5'd7, 32'h1234, 0, 5'd0, 1, 5'd7, 5'd7, 5'd30, 32'h0, 32'h0, 32'h0, 3'b000, "b_no_bypass");
      b_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd7, 5'd30, 5'd23, 32'h1234, 32'h0, 32'h0, 3'b000, "b_readback");
      b_op(0, 5'd0, 32'h0, 1, 5'd30, 1, 5'd30, 5'd30, 5'd30, 32'h0, 32'h0, 32'h0, 3'b000, "b_addr30");
      b_op(1, 5'd23, 32'h77, 1, 5'd23, 1, 5'd23, 5'd23, 5'd0, 32'h0, 32'h0, 32'h0, 3'b011, "b_top");
      b_op(0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd23, 5'd22, 5'd30, 32'h77, 32'h0, 32'h0, 3'b001, "b_top_rd");

      repeat (3) @(posedge clk);
      #1;
      chk("a_queue_drained", 96'(qa.size()), 96'(0));
      chk("b_queue_drained", 96'(qb.size()), 96'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
